// File: rtl/apb_master_bridge.sv
// apb_master_bridge
//
// Single-outstanding request/response to APB master bridge. A request taken on
// the valid/ready request channel is run through the APB SETUP and ACCESS
// phases, and the read data and error status come back on the valid/ready
// response channel. Misaligned requests are answered with an error and never
// reach the APB bus.
//
// Optional feature (compile-time macro APB_MASTER_TIMEOUT_EN): an ACCESS-phase
// watchdog aborts a transfer with an error after TIMEOUT_CYCLES cycles without
// PREADY. Without the macro the bridge waits for PREADY indefinitely.
//
// Parameters:
//   ADDR_WIDTH      width of req_addr / M_PADDR
//   DATA_WIDTH      width of the write and read data paths
//   TIMEOUT_CYCLES  ACCESS cycles before abort (watchdog builds only), >= 2
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   req_valid/req_ready       request handshake; req_ready is high only in IDLE
//   req_write/addr/wdata      request direction, byte address, write data
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata/rsp_err         read data (0 for writes/errors), error flag
//   M_PSEL..M_PWDATA          APB master outputs (all registered)
//   M_PREADY/PSLVERR/PRDATA   APB slave returns

module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  M_PSEL,
  output logic                  M_PENABLE,
  output logic [ADDR_WIDTH-1:0] M_PADDR,
  output logic                  M_PWRITE,
  output logic [DATA_WIDTH-1:0] M_PWDATA,
  input  logic                  M_PREADY,
  input  logic                  M_PSLVERR,
  input  logic [DATA_WIDTH-1:0] M_PRDATA
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state, state_next;
  logic                  psel_next, penable_next, pwrite_next;
  logic                  rsp_valid_next, rsp_err_next;
  logic [ADDR_WIDTH-1:0] paddr_next;
  logic [DATA_WIDTH-1:0] pwdata_next, rsp_rdata_next;
  logic                  timeout_hit;

  // The watchdog comparison needs at least one wait cycle to count.
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("apb_master_bridge: TIMEOUT_CYCLES must be >= 2");
  end

  assign req_ready = (state == IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] timeout_cnt;

  // Abort fires in the final counted cycle only if the slave is still not
  // ready, so a PREADY arriving in that same cycle completes normally.
  assign timeout_hit = (state == ACCESS) && !M_PREADY && (timeout_cnt == CNT_LAST);

  // Wait-cycle counter: held at zero outside ACCESS so every ACCESS phase
  // starts counting from zero, then advances on each cycle without PREADY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_cnt <= '0;
    end else if (state != ACCESS) begin
      timeout_cnt <= '0;
    end else if (!M_PREADY && !timeout_hit) begin
      timeout_cnt <= timeout_cnt + CNT_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and next-output logic. Every APB and response output is
  // registered, so this block computes the value each one takes at the next
  // edge; anything not touched here simply holds.
  always_comb begin
    state_next     = state;
    psel_next      = M_PSEL;
    penable_next   = M_PENABLE;
    paddr_next     = M_PADDR;
    pwrite_next    = M_PWRITE;
    pwdata_next    = M_PWDATA;
    rsp_valid_next = rsp_valid;
    rsp_rdata_next = rsp_rdata;
    rsp_err_next   = rsp_err;

    unique case (state)
      IDLE: begin
        if (req_valid) begin
          paddr_next  = req_addr;
          pwrite_next = req_write;
          pwdata_next = req_wdata;
          if (req_addr[1:0] == 2'b00) begin
            psel_next  = 1'b1;
            state_next = SETUP;
          end else begin
            // Misaligned: answer straight away, the APB bus stays quiet.
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
            rsp_rdata_next = '0;
            state_next     = RESP;
          end
        end
      end

      SETUP: begin
        penable_next = 1'b1;
        state_next   = ACCESS;
      end

      ACCESS: begin
        if (M_PREADY) begin
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = M_PSLVERR;
          rsp_rdata_next = M_PWRITE ? '0 : M_PRDATA;
          state_next     = RESP;
        end else if (timeout_hit) begin
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
          rsp_rdata_next = '0;
          state_next     = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State and output registers. Reset drops any in-flight transfer without
  // producing a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      M_PSEL    <= 1'b0;
      M_PENABLE <= 1'b0;
      M_PADDR   <= '0;
      M_PWRITE  <= 1'b0;
      M_PWDATA  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_next;
      M_PSEL    <= psel_next;
      M_PENABLE <= penable_next;
      M_PADDR   <= paddr_next;
      M_PWRITE  <= pwrite_next;
      M_PWDATA  <= pwdata_next;
      rsp_valid <= rsp_valid_next;
      rsp_rdata <= rsp_rdata_next;
      rsp_err   <= rsp_err_next;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
//
// Self-checking bench for apb_master_bridge. A transaction-level model (busy
// flag, cycles since accept, completion flag) predicts every output each
// cycle; directed sequences with literal expectations pin the model, then a
// randomized requester/slave exercises the rest. Build with
// APB_MASTER_TIMEOUT_EN defined to also check the watchdog abort.

module tb_apb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          M_PSEL, M_PENABLE, M_PWRITE, M_PREADY, M_PSLVERR;
  logic [AW-1:0] M_PADDR;
  logic [DW-1:0] M_PWDATA, M_PRDATA;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  apb_master_bridge #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .M_PSEL(M_PSEL), .M_PENABLE(M_PENABLE), .M_PADDR(M_PADDR),
    .M_PWRITE(M_PWRITE), .M_PWDATA(M_PWDATA),
    .M_PREADY(M_PREADY), .M_PSLVERR(M_PSLVERR), .M_PRDATA(M_PRDATA)
  );

  // One comparison: counts it, and reports actual vs required on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, required 0x%0h", name, $time, act, exp);
    end
  endtask

  // Drive every input for one clock cycle, returning 1 time unit after the
  // edge that ends the cycle.
  task automatic applyStimulus(input logic v, input logic w, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic rr, input logic pr,
                               input logic se, input logic [DW-1:0] prd);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    rsp_ready = rr;
    M_PREADY  = pr;
    M_PSLVERR = se;
    M_PRDATA  = prd;
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: a transaction is either absent, in flight (m_age edges
  // since it was accepted), or completed and waiting for its response
  // handshake.
  bit            m_busy    = 1'b0;
  bit            m_aligned = 1'b0;
  bit            m_done    = 1'b0;
  int            m_age     = 0;
  logic [AW-1:0] m_paddr   = '0;
  logic          m_pwrite  = 1'b0;
  logic [DW-1:0] m_pwdata  = '0;
  logic [DW-1:0] m_rdata   = '0;
  logic          m_err     = 1'b0;

  // Compare process: mid-cycle, check the DUT against the model, then advance
  // the model with the inputs that will be seen at the coming edge.
  always @(negedge clk) begin
    bit on_bus;
    if (rst) begin
      m_busy = 1'b0; m_aligned = 1'b0; m_done = 1'b0; m_age = 0;
      m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0; m_rdata = '0; m_err = 1'b0;
      checkOutput("rst_req_ready", req_ready, 1);
      checkOutput("rst_psel", M_PSEL, 0);
      checkOutput("rst_penable", M_PENABLE, 0);
      checkOutput("rst_paddr", M_PADDR, 0);
      checkOutput("rst_pwrite", M_PWRITE, 0);
      checkOutput("rst_pwdata", M_PWDATA, 0);
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      checkOutput("rst_rsp_rdata", rsp_rdata, 0);
      checkOutput("rst_rsp_err", rsp_err, 0);
    end else begin
      on_bus = m_busy && m_aligned && !m_done;
      checkOutput("req_ready", req_ready, !m_busy);
      checkOutput("psel", M_PSEL, on_bus);
      checkOutput("penable", M_PENABLE, on_bus && (m_age >= 2));
      checkOutput("paddr", M_PADDR, m_paddr);
      checkOutput("pwrite", M_PWRITE, m_pwrite);
      checkOutput("pwdata", M_PWDATA, m_pwdata);
      checkOutput("rsp_valid", rsp_valid, m_busy && m_done);
      if (m_busy && m_done) begin
        checkOutput("rsp_rdata", rsp_rdata, m_rdata);
        checkOutput("rsp_err", rsp_err, m_err);
      end

      if (!m_busy) begin
        if (req_valid) begin
          m_busy    = 1'b1;
          m_age     = 1;
          m_aligned = (req_addr % 4 == 0);
          m_paddr   = req_addr;
          m_pwrite  = req_write;
          m_pwdata  = req_wdata;
          m_done    = !m_aligned;
          if (!m_aligned) begin
            m_err   = 1'b1;
            m_rdata = '0;
          end
        end
      end else if (!m_done) begin
        if (m_age >= 2 && M_PREADY) begin
          m_done  = 1'b1;
          m_err   = M_PSLVERR;
          m_rdata = m_pwrite ? '0 : M_PRDATA;
        end
`ifdef APB_MASTER_TIMEOUT_EN
        else if (m_age >= 2 && (m_age - 1) == TO) begin
          m_done  = 1'b1;
          m_err   = 1'b1;
          m_rdata = '0;
        end
`endif
        else begin
          m_age++;
        end
      end else if (rsp_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  initial begin
    bit            pending;
    bit            acc;
    logic          r_write, r_se;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    int            n_access;

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; M_PREADY = 1'b0; M_PSLVERR = 1'b0; M_PRDATA = '0;
    #2;
    checkOutput("reset_psel", M_PSEL, 0);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_req_ready", req_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] write 0x4 <- 0xA5, zero-wait slave");
    applyStimulus(1, 1, 32'h4, 32'hA5, 1, 1, 0, 0);
    checkOutput("t1_setup_psel", M_PSEL, 1);
    checkOutput("t1_setup_penable", M_PENABLE, 0);
    checkOutput("t1_paddr", M_PADDR, 32'h4);
    checkOutput("t1_pwrite", M_PWRITE, 1);
    checkOutput("t1_pwdata", M_PWDATA, 32'hA5);
    checkOutput("t1_req_ready_busy", req_ready, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
    checkOutput("t1_access_psel", M_PSEL, 1);
    checkOutput("t1_access_penable", M_PENABLE, 1);
    checkOutput("t1_rsp_valid_early", rsp_valid, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 32'hFFFF);
    checkOutput("t1_rsp_valid", rsp_valid, 1);
    checkOutput("t1_rsp_err", rsp_err, 0);
    checkOutput("t1_rsp_rdata", rsp_rdata, 0);
    checkOutput("t1_resp_psel", M_PSEL, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("t1_back_idle", req_ready, 1);

    $display("[TB] read 0xC, three wait states, then held response");
    applyStimulus(1, 0, 32'hC, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t2_penable_high", M_PENABLE, 1);
      checkOutput("t2_paddr_stable", M_PADDR, 32'hC);
      applyStimulus(0, 0, 0, 0, 0, (i == 3), 0, (i == 3) ? 32'h1E1E : 32'hDEAD);
    end
    checkOutput("t2_penable_low", M_PENABLE, 0);
    for (int k = 0; k < 5; k++) begin
      checkOutput("t5_rsp_valid_held", rsp_valid, 1);
      checkOutput("t5_rsp_rdata_held", rsp_rdata, 32'h1E1E);
      checkOutput("t5_rsp_err_held", rsp_err, 0);
      checkOutput("t5_req_ready_low", req_ready, 0);
      applyStimulus(1, 0, 32'h10, 0, 0, 1, 1, 0);
    end

    $display("[TB] read 0x10 with slave error");
    applyStimulus(1, 0, 32'h10, 0, 1, 1, 1, 0);
    checkOutput("t3_idle_after_hs", req_ready, 1);
    applyStimulus(1, 0, 32'h10, 0, 1, 1, 1, 0);
    checkOutput("t3_setup_psel", M_PSEL, 1);
    checkOutput("t3_paddr", M_PADDR, 32'h10);
    applyStimulus(0, 0, 0, 0, 1, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 1, 0);
    checkOutput("t3_rsp_err", rsp_err, 1);
    checkOutput("t3_rsp_rdata", rsp_rdata, 0);
    applyStimulus(1, 1, 32'h6, 32'h77, 0, 0, 0, 0);
    checkOutput("t3_blocked_until_hs", req_ready, 0);
    applyStimulus(1, 1, 32'h6, 32'h77, 1, 0, 0, 0);
    checkOutput("t3_ready_after_hs", req_ready, 1);

    $display("[TB] misaligned request to 0x6");
    applyStimulus(1, 1, 32'h6, 32'h77, 1, 0, 0, 0);
    checkOutput("t4_no_psel", M_PSEL, 0);
    checkOutput("t4_rsp_valid", rsp_valid, 1);
    checkOutput("t4_rsp_err", rsp_err, 1);
    checkOutput("t4_rsp_rdata", rsp_rdata, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);

    $display("[TB] async reset during ACCESS wait");
    applyStimulus(1, 0, 32'h8, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("t6_in_access", M_PENABLE, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t6_async_psel", M_PSEL, 0);
    checkOutput("t6_async_penable", M_PENABLE, 0);
    checkOutput("t6_async_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("t6_ready_after_rst", req_ready, 1);

    $display("[TB] slave that never readies");
    applyStimulus(1, 0, 32'h40, 0, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    n_access = 0;
    for (int n = 0; n < 40 && !rsp_valid; n++) begin
      if (M_PENABLE) n_access++;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    end
`ifdef APB_MASTER_TIMEOUT_EN
    checkOutput("to_access_cycles", n_access, TO);
    checkOutput("to_rsp_valid", rsp_valid, 1);
    checkOutput("to_rsp_err", rsp_err, 1);
    checkOutput("to_rsp_rdata", rsp_rdata, 0);
    checkOutput("to_psel", M_PSEL, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
`else
    checkOutput("nto_access_cycles", n_access, 40);
    checkOutput("nto_psel", M_PSEL, 1);
    applyStimulus(0, 0, 0, 0, 1, 1, 0, 32'h55);
    checkOutput("nto_rsp_valid", rsp_valid, 1);
    checkOutput("nto_rsp_rdata", rsp_rdata, 32'h55);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
`endif

    $display("[TB] randomized traffic");
    pending = 1'b0;
    r_write = 1'b0; r_addr = '0; r_wdata = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!pending && ($urandom_range(0, 1) == 1)) begin
        pending = 1'b1;
        r_write = 1'($urandom_range(0, 1));
        r_addr  = $urandom();
        if ($urandom_range(0, 4) != 0) r_addr[1:0] = 2'b00;
        r_wdata = $urandom();
      end
      r_se = ($urandom_range(0, 4) == 0);
      acc  = pending && req_ready;
      applyStimulus(pending, r_write, r_addr, r_wdata,
                    ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0),
                    r_se, r_se ? '0 : DW'($urandom()));
      if (acc) pending = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Single-outstanding request-to-APB master bridge that sits directly upstream of the peripheral APB wrappers (e.g. the multiplier register wrapper) and drives their PSEL/PENABLE/PADDR/PWRITE/PWDATA inputs. It takes a valid/ready request from the system side, sequences the APB SETUP and ACCESS phases, waits on PREADY, and returns read data and error status on a valid/ready response channel. An optional watchdog aborts transfers to slaves that never assert PREADY.

Parameters:
ADDR_WIDTH, 32, width of req_addr and M_PADDR
DATA_WIDTH, 32, width of write/read data paths
TIMEOUT_CYCLES, 16, ACCESS-phase cycles before abort (used only with the optional feature); must be >=2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  bridge can accept a request
req_write  input  1  1=write, 0=read
req_addr  input  ADDR_WIDTH  byte address
req_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  response present
rsp_ready  input  1  response consumer ready
rsp_rdata  output  DATA_WIDTH  read data (0 for writes/errors)
rsp_err  output  1  transfer error
M_PSEL  output  1  APB select
M_PENABLE  output  1  APB enable
M_PADDR  output  ADDR_WIDTH  APB address
M_PWRITE  output  1  APB direction
M_PWDATA  output  DATA_WIDTH  APB write data
M_PREADY  input  1  slave ready
M_PSLVERR  input  1  slave error
M_PRDATA  input  DATA_WIDTH  slave read data

Behaviour:
- Reset (async, immediate, also mid-transfer): state IDLE; M_PSEL=0, M_PENABLE=0, M_PADDR=0, M_PWRITE=0, M_PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter=0. Any in-flight transfer is dropped without a response.
- All outputs are registered except req_ready, which is 1 if and only if state==IDLE.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: on req_valid&req_ready, latch addr/write/wdata into M_PADDR/M_PWRITE/M_PWDATA.
  - Aligned address (req_addr[1:0]==0): go to SETUP.
  - Misaligned address: go to RESP with rsp_err=1 and rsp_rdata=0. No APB activity.
- SETUP: M_PSEL=1, M_PENABLE=0 for exactly one cycle, then ACCESS.
- ACCESS: M_PSEL=1, M_PENABLE=1. PADDR, PWRITE and PWDATA are held stable. The bridge stays while M_PREADY=0. On the first cycle with M_PREADY=1:
  - capture rsp_rdata = M_PRDATA for reads (0 for writes);
  - capture rsp_err = M_PSLVERR;
  - deassert M_PSEL and M_PENABLE on the next edge;
  - go to RESP.
- RESP: rsp_valid=1, with rsp_rdata and rsp_err held. When rsp_valid&rsp_ready, clear rsp_valid and go to IDLE. M_PADDR, M_PWRITE and M_PWDATA retain their last values while idle.
- Latency: the accept edge, one SETUP cycle, N>=1 ACCESS cycles and one RESP cycle give rsp_valid 3 cycles after acceptance with zero-wait slaves. The minimum interval between accepts is 4 cycles with rsp_ready held high.
- M_PSLVERR is sampled only when M_PREADY=1 in ACCESS. rsp_err is never set from M_PSLVERR in any other cycle.
- A req_valid arriving while not in IDLE is not accepted (req_ready=0). The requester must hold it stable until accepted.
- A slave that holds M_PREADY=1 permanently still gets the full SETUP then ACCESS sequence. It is never skipped.

Optional Feature:
APB_MASTER_TIMEOUT_EN
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle with M_PREADY=0. When it reaches TIMEOUT_CYCLES-1 and M_PREADY is still 0, the bridge:
  - drops M_PSEL and M_PENABLE on the next edge;
  - sets rsp_err=1 and rsp_rdata=0;
  - goes to RESP.
  - A PREADY=1 arriving in that same final cycle wins: it is a normal completion.
- Undefined: no counter logic. ACCESS waits indefinitely for M_PREADY.

Test Plan:
- Write 0x0000_0004 <- 0x0000_00A5, slave zero-wait -> SETUP then ACCESS one cycle each with PADDR=0x4, PWRITE=1, PWDATA=0xA5; rsp_valid 3 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read 0x0000_000C, slave inserts 3 wait states then returns PRDATA=0x0000_1E1E -> PENABLE high 4 cycles with PADDR stable; rsp_rdata=0x1E1E, rsp_err=0.
- Read 0x0000_0010, slave returns PREADY=1 with PSLVERR=1 -> rsp_err=1; next request accepted only after the rsp_valid&rsp_ready handshake.
- Request to 0x0000_0006 -> no PSEL pulse; rsp_valid next cycle with rsp_err=1, rsp_rdata=0.
- rsp_ready held low 5 cycles after a read -> rsp_valid, rsp_rdata and rsp_err stable; req_ready=0 throughout.
- rst asserted in ACCESS mid-wait -> M_PSEL, M_PENABLE and rsp_valid go 0 asynchronously; after release req_ready=1. With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, a slave that never readies gives abort with rsp_err=1 after 16 ACCESS cycles.
